// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory port arbiter.
//   arb_state_t : arbiter FSM state
//   pick_t      : result of winner selection
//   mem_req_t   : one memory-port access (address, write, store data, funct3)
package mem_arb_pkg;

  localparam int unsigned ArbAddrW = 32;
  localparam int unsigned ArbDataW = 32;
  localparam int unsigned Funct3W  = 3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCoreGnt = 3'd1,
    StCoreAck = 3'd2,
    StDmaGnt  = 3'd3,
    StDmaAck  = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    PickNone = 2'd0,
    PickCore = 2'd1,
    PickDma  = 2'd2
  } pick_t;

  typedef struct packed {
    logic [ArbAddrW-1:0] adr;
    logic                we;
    logic [ArbDataW-1:0] wdata;
    logic [Funct3W-1:0]  funct3;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port arbiter.
//   core_req, dma_req : live requests
//   last_dma          : 1 if the previous grant went to DMA
//   dma_lock          : DMA burst hint
//   burst_cnt         : DMA grants in the current locked burst
//   pick              : winner (none / core / DMA)
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 16,
  localparam int unsigned CntW    = $clog2(LOCK_MAX + 1)
) (
  input  logic            core_req,
  input  logic            dma_req,
  input  logic            last_dma,
  input  logic            dma_lock,
  input  logic [CntW-1:0] burst_cnt,
  output pick_t           pick
);

  localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

  logic lock_win;

  always_comb begin
    lock_win = dma_lock && (burst_cnt < LockMaxC);
    pick     = PickNone;
    if (core_req && dma_req) begin
      // Lock overrides round-robin until the burst budget is spent.
      pick = (lock_win || !last_dma) ? PickDma : PickCore;
    end else if (core_req) begin
      pick = PickCore;
    end else if (dma_req) begin
      pick = PickDma;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single unified memory port.
// Each access takes a GNT cycle (memory port driven from the winner's live inputs,
// writes commit at its end) followed by an ACK cycle (ack pulse + read data).
//   clk, reset          : clock, async active-low reset
//   core_* / dma_*      : requester ports (req, adr, we, wdata, funct3 in; rdata, ack out)
//   dma_lock            : DMA burst hint, sampled at arbitration
//   core_stall          : core_req & ~core_ack, used by the core as state-hold enable
//   mem_*               : shared synchronous-read memory port
//   grant_dma           : DMA owns the port (DMA_GNT or DMA_ACK)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ArbAddrW,
  parameter int unsigned DATA_W   = ArbDataW,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic              core_we,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_adr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [2:0]        dma_funct3,
  input  logic              dma_lock,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dma
);

  localparam int unsigned     CntW     = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

  arb_state_t      state_q, state_d;
  logic            last_dma_q, last_dma_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  pick_t           pick;
  mem_req_t        core_side, dma_side, mem_side;

  mem_arb_pick #(
    .LOCK_MAX (LOCK_MAX)
  ) u_pick (
    .core_req  (core_req),
    .dma_req   (dma_req),
    .last_dma  (last_dma_q),
    .dma_lock  (dma_lock),
    .burst_cnt (burst_cnt_q),
    .pick      (pick)
  );

  // Next-state: arbitration in IDLE and both ACK states, GNT always advances to ACK.
  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      StCoreGnt: state_d = StCoreAck;
      StDmaGnt:  state_d = StDmaAck;
      default: begin
        case (pick)
          PickCore: state_d = StCoreGnt;
          PickDma:  state_d = StDmaGnt;
          default:  state_d = StIdle;
        endcase
        if (pick == PickCore) begin
          last_dma_d  = 1'b0;
          burst_cnt_d = '0;
        end else begin
          if (pick == PickDma) begin
            last_dma_d = 1'b1;
          end
          // An unlocked arbitration ends any burst, so an unlocked DMA grant is not
          // counted against the next locked burst.
          if (!dma_lock) begin
            burst_cnt_d = '0;
          end else if ((pick == PickDma) && (burst_cnt_q != LockMaxC)) begin
            burst_cnt_d = burst_cnt_q + CntW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_dma_q  <= 1'b1;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Port mux; all outputs decode from registered state so reset clears them at once.
  always_comb begin
    core_side.adr    = ArbAddrW'(core_adr);
    core_side.we     = core_we;
    core_side.wdata  = ArbDataW'(core_wdata);
    core_side.funct3 = core_funct3;
    dma_side.adr     = ArbAddrW'(dma_adr);
    dma_side.we      = dma_we;
    dma_side.wdata   = ArbDataW'(dma_wdata);
    dma_side.funct3  = dma_funct3;
    mem_side         = '0;
    if (state_q == StCoreGnt) begin
      mem_side = core_side;
    end else if (state_q == StDmaGnt) begin
      mem_side = dma_side;
    end
  end

  assign mem_adr    = ADDR_W'(mem_side.adr);
  assign mem_we     = mem_side.we;
  assign mem_wdata  = DATA_W'(mem_side.wdata);
  assign mem_funct3 = mem_side.funct3;

  assign core_ack   = (state_q == StCoreAck);
  assign dma_ack    = (state_q == StDmaAck);
  assign core_rdata = core_ack ? mem_rdata : '0;
  assign dma_rdata  = dma_ack ? mem_rdata : '0;
  assign core_stall = core_req & ~core_ack;
  assign grant_dma  = (state_q == StDmaGnt) || (state_q == StDmaAck);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps, then randomized
// requesters checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req, core_we, dma_req, dma_we, dma_lock;
  logic [31:0] core_adr, core_wdata, dma_adr, dma_wdata;
  logic [2:0]  core_funct3, dma_funct3;
  logic [31:0] core_rdata, dma_rdata, mem_adr, mem_wdata, mem_rdata;
  logic        core_ack, core_stall, dma_ack, mem_we, grant_dma;
  logic [2:0]  mem_funct3;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .LOCK_MAX (LM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_adr    (core_adr),
    .core_we     (core_we),
    .core_wdata  (core_wdata),
    .core_funct3 (core_funct3),
    .core_rdata  (core_rdata),
    .core_ack    (core_ack),
    .core_stall  (core_stall),
    .dma_req     (dma_req),
    .dma_adr     (dma_adr),
    .dma_we      (dma_we),
    .dma_wdata   (dma_wdata),
    .dma_funct3  (dma_funct3),
    .dma_lock    (dma_lock),
    .dma_rdata   (dma_rdata),
    .dma_ack     (dma_ack),
    .mem_adr     (mem_adr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_funct3  (mem_funct3),
    .mem_rdata   (mem_rdata),
    .grant_dma   (grant_dma)
  );

  always #5 clk = ~clk;

  // Word memory behind the port; unwritten words read a fixed address pattern.
  logic [31:0] mem   [256];
  bit          mem_v [256];

  function automatic logic [31:0] init_word(input int idx);
    return (idx == 64) ? 32'hDEADBEEF : 32'h5A5A_0000 + 32'(idx);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_adr[9:2]]   <= mem_wdata;
      mem_v[mem_adr[9:2]] <= 1'b1;
    end
    mem_rdata <= mem_v[mem_adr[9:2]] ? mem[mem_adr[9:2]] : init_word(int'(mem_adr[9:2]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    core_req = 0; core_we = 0; core_adr = 0; core_wdata = 0; core_funct3 = 0;
    dma_req = 0; dma_we = 0; dma_adr = 0; dma_wdata = 0; dma_funct3 = 0; dma_lock = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model state (random phase).
  int          cur_gnt, cur_ack, win, m_cnt, g;
  bit          m_last;
  bit          act   [3];
  logic [31:0] r_adr [3];
  logic [31:0] r_wd  [3];
  logic        r_we  [3];
  logic [2:0]  r_f3  [3];
  logic [31:0] exp_rd[3];
  logic [31:0] smem  [256];

  initial begin
    clear_inputs();
    #2;
    chk("rst_core_ack", 32'(core_ack), 0);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_grant_dma", 32'(grant_dma), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_core_stall", 32'(core_stall), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Core-only read of 0x100.
    tick();
    core_req = 1; core_adr = 32'h100; core_funct3 = 3'b010;
    #1;
    chk("rd_c0_stall", 32'(core_stall), 1);
    chk("rd_c0_mem_adr", mem_adr, 0);
    tick();
    chk("rd_c1_mem_adr", mem_adr, 32'h100);
    chk("rd_c1_mem_we", 32'(mem_we), 0);
    chk("rd_c1_funct3", 32'(mem_funct3), 2);
    chk("rd_c1_stall", 32'(core_stall), 1);
    chk("rd_c1_ack", 32'(core_ack), 0);
    tick();
    chk("rd_c2_ack", 32'(core_ack), 1);
    chk("rd_c2_rdata", core_rdata, 32'hDEADBEEF);
    chk("rd_c2_stall", 32'(core_stall), 0);
    core_req = 0;
    tick();
    chk("rd_c3_ack", 32'(core_ack), 0);
    chk("rd_c3_rdata", core_rdata, 0);

    // DMA write of 0x12345678 to 0x40.
    dma_req = 1; dma_we = 1; dma_adr = 32'h40; dma_wdata = 32'h12345678; dma_funct3 = 3'b010;
    #1;
    chk("wr_c0_grant", 32'(grant_dma), 0);
    tick();
    chk("wr_c1_mem_we", 32'(mem_we), 1);
    chk("wr_c1_mem_adr", mem_adr, 32'h40);
    chk("wr_c1_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_c1_grant", 32'(grant_dma), 1);
    chk("wr_c1_ack", 32'(dma_ack), 0);
    tick();
    chk("wr_c2_mem_we", 32'(mem_we), 0);
    chk("wr_c2_mem_adr", mem_adr, 0);
    chk("wr_c2_ack", 32'(dma_ack), 1);
    chk("wr_c2_grant", 32'(grant_dma), 1);
    dma_req = 0; dma_we = 0;
    tick();
    chk("wr_c3_grant", 32'(grant_dma), 0);
    chk("wr_c3_ack", 32'(dma_ack), 0);

    // Core read-back with req dropped during GNT.
    core_req = 1; core_adr = 32'h40;
    tick();
    chk("drop_gnt_adr", mem_adr, 32'h40);
    core_req = 0;
    tick();
    chk("drop_ack", 32'(core_ack), 1);
    chk("drop_rdata", core_rdata, 32'h12345678);
    tick();
    chk("drop_idle_ack", 32'(core_ack), 0);
    chk("drop_idle_adr", mem_adr, 0);
    tick();
    chk("drop_no_regrant_ack", 32'(core_ack), 0);
    chk("drop_no_regrant_adr", mem_adr, 0);

    // Lock burst: LM DMA accesses, one core, LM DMA.
    reset = 1'b0;
    core_req = 1; core_adr = 32'h200; dma_req = 1; dma_adr = 32'h300; dma_lock = 1;
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk($sformatf("lock_core_ack_%0d", i), 32'(core_ack), 32'(i == 10));
      chk($sformatf("lock_dma_ack_%0d", i), 32'(dma_ack), 32'((i % 2 == 0) && (i != 10)));
      chk($sformatf("lock_grant_%0d", i), 32'(grant_dma), 32'((i != 9) && (i != 10)));
    end

    // Async reset in the middle of a DMA_GNT write.
    core_req = 0; dma_lock = 0; dma_we = 1; dma_adr = 32'h80; dma_wdata = 32'hCAFEF00D;
    tick();
    chk("arst_pre_mem_we", 32'(mem_we), 1);
    chk("arst_pre_grant", 32'(grant_dma), 1);
    #2;
    reset = 1'b0;
    core_req = 1;
    #1;
    chk("arst_mem_we", 32'(mem_we), 0);
    chk("arst_grant", 32'(grant_dma), 0);
    chk("arst_dma_ack", 32'(dma_ack), 0);
    chk("arst_core_ack", 32'(core_ack), 0);
    chk("arst_mem_adr", mem_adr, 0);
    dma_we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    // Both requesting, no lock: strict alternation starting with the core.
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) chk("alt_first_adr", mem_adr, 32'h200);
      chk($sformatf("alt_core_ack_%0d", i), 32'(core_ack), 32'(i % 4 == 2));
      chk($sformatf("alt_dma_ack_%0d", i), 32'(dma_ack), 32'(i % 4 == 0));
      chk($sformatf("alt_grant_%0d", i), 32'(grant_dma), 32'((i % 4 == 3) || (i % 4 == 0)));
    end

    // Randomized phase against the reference model.
    clear_inputs();
    do_reset();
    for (int i = 0; i < 256; i++) smem[i] = mem_v[i] ? mem[i] : init_word(i);
    cur_gnt = 0; cur_ack = 0; m_last = 1; m_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      act[r] = 0; r_adr[r] = 0; r_wd[r] = 0; r_we[r] = 0; r_f3[r] = 0; exp_rd[r] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int r = 1; r <= 2; r++) begin
        if (cur_ack == r) act[r] = 0;
        if (!act[r] && ($urandom_range(0, 2) == 0)) begin
          act[r]   = 1;
          r_adr[r] = {22'd0, 8'($urandom), 2'b00};
          r_we[r]  = 1'($urandom);
          r_wd[r]  = $urandom;
          r_f3[r]  = 3'($urandom);
        end
      end
      dma_lock = ($urandom_range(0, 3) != 0);
      core_req = act[1]; core_adr = r_adr[1]; core_we = r_we[1];
      core_wdata = r_wd[1]; core_funct3 = r_f3[1];
      dma_req = act[2]; dma_adr = r_adr[2]; dma_we = r_we[2];
      dma_wdata = r_wd[2]; dma_funct3 = r_f3[2];
      #1;
      chk("rnd_core_ack", 32'(core_ack), 32'(cur_ack == 1));
      chk("rnd_dma_ack", 32'(dma_ack), 32'(cur_ack == 2));
      chk("rnd_grant", 32'(grant_dma), 32'((cur_gnt == 2) || (cur_ack == 2)));
      chk("rnd_stall", 32'(core_stall), 32'(act[1] && (cur_ack != 1)));
      chk("rnd_core_rdata", core_rdata, (cur_ack == 1) ? exp_rd[1] : 32'd0);
      chk("rnd_dma_rdata", dma_rdata, (cur_ack == 2) ? exp_rd[2] : 32'd0);
      g = cur_gnt;
      chk("rnd_mem_adr", mem_adr, (g != 0) ? r_adr[g] : 32'd0);
      chk("rnd_mem_we", 32'(mem_we), (g != 0) ? 32'(r_we[g]) : 32'd0);
      chk("rnd_mem_wdata", mem_wdata, (g != 0) ? r_wd[g] : 32'd0);
      chk("rnd_mem_funct3", 32'(mem_funct3), (g != 0) ? 32'(r_f3[g]) : 32'd0);
      // Advance model: access in flight completes, otherwise arbitrate.
      if (g != 0) begin
        exp_rd[g] = smem[r_adr[g][9:2]];
        if (r_we[g]) smem[r_adr[g][9:2]] = r_wd[g];
        win = 0;
      end else begin
        if (act[1] && act[2]) win = (dma_lock && (m_cnt < LM)) ? 2 : (m_last ? 1 : 2);
        else if (act[1]) win = 1;
        else if (act[2]) win = 2;
        else win = 0;
        if (win == 1) begin
          m_last = 0; m_cnt = 0;
        end else begin
          if (win == 2) m_last = 1;
          if (!dma_lock) m_cnt = 0;
          else if (win == 2 && m_cnt < LM) m_cnt++;
        end
      end
      cur_ack = g;
      cur_gnt = win;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
